key_sched_iter: RTL and testbench
=================================

KEY_SCHED_ITER -- requirements
Module: key_sched_iter

Interface
REQ-001 Parameter KEY_W, default 64: master key width; SHALL be a multiple of 16 and at least 64.
REQ-002 Parameter NROUNDS, default 25: number of round keys emitted per key; SHALL satisfy 1 <= NROUNDS <= 2^RC_W - 1.
REQ-003 Parameter RC_W, default 5: round-constant width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 key_in  in  KEY_W  master key; row r = key_in[16r+15:16r], with row 0 the least significant.
REQ-007 key_valid  in  1  key_in offered.
REQ-008 key_ready  out  1  block accepts a key this cycle.
REQ-009 rk_out  out  32  current round key.
REQ-010 rk_idx  out  RC_W  index of rk_out, counting from 0.
REQ-011 rk_valid  out  1  rk_out/rk_idx valid.
REQ-012 rk_ready  in  1  consumer accepts rk_out.
REQ-013 busy  out  1  high while a schedule is in progress.
REQ-014 done  out  1  one-cycle pulse after the last round key is accepted.

Function
REQ-015 FSM states: IDLE and RUN only.
REQ-016 IDLE outputs: key_ready=1, rk_valid=0, busy=0.
REQ-017 IDLE: when key_valid=1, SHALL load state <= key_in and idx <= 0, then enter RUN.
REQ-018 RUN outputs: key_ready=0, rk_valid=1, busy=1, rk_out=state[31:0], rk_idx=idx.
- key_valid SHALL be ignored in RUN.
REQ-019 RUN, on rk_valid & rk_ready with idx < NROUNDS-1: state <= R(state, idx+1) and idx <= idx+1.
REQ-020 RUN, on rk_valid & rk_ready with idx = NROUNDS-1: go to IDLE and assert done for exactly the next cycle.
- state SHALL be held, not updated.
REQ-021 RUN with rk_ready=0: SHALL hold state, idx and all outputs unchanged for any number of cycles.
REQ-022 R(state, rc), step 1 (S-layer): for each bit position j in 0..15, the nibble {row3[j],row2[j],row1[j],row0[j]} SHALL be replaced via the 4-bit S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (input 0..F).
- Rows 4 and above pass through step 1 unchanged.
REQ-023 R, step 2 (mix): t = row0 ^ rotl16(row1, 8).
- row'[k] = row[k+1] for k = 0..N-2, with N = KEY_W/16.
- row'[N-1] = t.
REQ-024 R, step 3 (round constant): row'[N-1][15:16-RC_W] ^= rc[RC_W-1:0].
REQ-025 Timing:
- First round key is valid the cycle after key acceptance.
- With rk_ready held high, one round key is issued per cycle.
- A full schedule occupies NROUNDS cycles in RUN.
REQ-026 Back-to-back: a new key is accepted no earlier than the cycle done is high; one IDLE cycle separates schedules.
REQ-027 R SHALL be combinational; critical path is one round, with no multicycle paths.

Reset
REQ-028 rst=1 SHALL force IDLE immediately (asynchronously), regardless of state.
- Values forced: state=0, idx=0, rk_out=0, rk_valid=0, done=0, busy=0, key_ready=0 while rst=1.
REQ-029 After rst deasserts, key_ready=1 from the first clock edge onward.
REQ-030 Reset mid-schedule SHALL discard the schedule; no done pulse is emitted.

Structure
REQ-031 The S-box table, the row width constant (16) and the FSM state encoding SHALL live in the shared cipher package.
REQ-032 The round function R SHALL be a separate combinational sub-module, key_round_fn, parametrised by KEY_W and RC_W.
REQ-033 Elaboration SHALL fail if the KEY_W or NROUNDS constraints are violated.

Verification
REQ-034 Zero key, KEY_W=64, rk_ready=1 -> rk 0 = 0x00000000 at idx 0; 25 keys, idx 0..24, on consecutive cycles; done high exactly once, the cycle after idx 24 is accepted.
REQ-035 Key 0x0123456789ABCDEF with a random rk_ready stall pattern -> issued sequence identical to the rk_ready=1 run; no idx skipped or repeated during stalls.
REQ-036 KEY_W=128, NROUNDS=31, random key -> all 31 round keys match a bit-exact software model of REQ-022..REQ-024.
REQ-037 rst asserted at idx 10 -> rk_valid=0 and key_ready=0 combinationally; no done pulse; a new key after release restarts at idx 0.
REQ-038 key_valid held high throughout -> second key accepted only in the cycle done is high; key_in changes during RUN have no effect on rk_out.

Source files
------------

// File: rtl/key_sched_iter_pkg.sv
// Shared cipher definitions for the iterative key schedule.
// Holds the row width, the 4-bit S-box and the FSM state encoding.
package key_sched_iter_pkg;

    localparam int ROW_W = 16;

    // Entry i sits at bits [4i+3:4i]; entry 0 is 0xC, entry 15 is 0x2.
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/key_round_fn.sv
// Combinational key-schedule round: bit-sliced S-layer over rows 0..3,
// row rotation with a mixed top row, then round-constant injection.
module key_round_fn
    import key_sched_iter_pkg::*;
#(
    parameter int KEY_W = 64,
    parameter int RC_W  = 5
) (
    input  logic [KEY_W-1:0] state_in,
    input  logic [RC_W-1:0]  rc,
    output logic [KEY_W-1:0] state_out
);

    logic [KEY_W-1:0] sub_state;
    logic [ROW_W-1:0] mixed;
    logic [3:0]       nibble;
    logic [3:0]       sub_nibble;

    // Each column j across rows 3..0 forms one S-box input; higher rows pass through.
    always_comb begin
        sub_state  = state_in;
        nibble     = '0;
        sub_nibble = '0;
        for (int j = 0; j < ROW_W; j++) begin
            nibble = {state_in[3*ROW_W + j], state_in[2*ROW_W + j],
                      state_in[ROW_W + j],   state_in[j]};
            sub_nibble = sbox(nibble);
            sub_state[j]           = sub_nibble[0];
            sub_state[ROW_W + j]   = sub_nibble[1];
            sub_state[2*ROW_W + j] = sub_nibble[2];
            sub_state[3*ROW_W + j] = sub_nibble[3];
        end
    end

    always_comb begin
        mixed = sub_state[ROW_W-1:0]
              ^ {sub_state[ROW_W+7:ROW_W], sub_state[2*ROW_W-1:ROW_W+8]};
        mixed = mixed ^ (ROW_W'(rc) << (ROW_W - RC_W));
    end

    assign state_out = {mixed, sub_state[KEY_W-1:ROW_W]};

endmodule

// File: rtl/key_sched_iter.sv
// Iterative key schedule: accepts a master key, then streams NROUNDS
// 32-bit round keys with a valid/ready handshake and a closing done pulse.
module key_sched_iter
    import key_sched_iter_pkg::*;
#(
    parameter int KEY_W   = 64,
    parameter int NROUNDS = 25,
    parameter int RC_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [31:0]      rk_out,
    output logic [RC_W-1:0]  rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
);

    if (KEY_W % ROW_W != 0 || KEY_W < 64) begin : g_bad_key_w
        $error("key_sched_iter: KEY_W must be a multiple of 16 and at least 64");
    end
    if (RC_W < 1 || RC_W > ROW_W) begin : g_bad_rc_w
        $error("key_sched_iter: RC_W must be between 1 and 16");
    end
    if (NROUNDS < 1 || NROUNDS > (1 << RC_W) - 1) begin : g_bad_nrounds
        $error("key_sched_iter: NROUNDS must be in 1 .. 2^RC_W-1");
    end

    fsm_state_t       cur_state;
    fsm_state_t       next_state;
    logic [KEY_W-1:0] key_state;
    logic [KEY_W-1:0] round_out;
    logic [RC_W-1:0]  idx;
    logic [RC_W-1:0]  idx_next;
    logic             done_q;
    logic             accept;
    logic             advance;
    logic             last;

    assign idx_next = idx + RC_W'(1);
    assign last     = (idx == RC_W'(NROUNDS - 1));
    assign accept   = (cur_state == IDLE) && key_valid;
    assign advance  = (cur_state == RUN) && rk_ready;

    // The next round key is prepared from the current state with constant idx+1.
    key_round_fn #(
        .KEY_W(KEY_W),
        .RC_W (RC_W)
    ) u_round (
        .state_in (key_state),
        .rc       (idx_next),
        .state_out(round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE: if (accept)          next_state = RUN;
            RUN:  if (advance && last) next_state = IDLE;
        endcase
    end

    // On the final handshake the state is held so rk_out stays stable into IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state <= '0;
            idx       <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= advance && last;
            if (accept) begin
                key_state <= key_in;
                idx       <= '0;
            end else if (advance && !last) begin
                key_state <= round_out;
                idx       <= idx_next;
            end
        end
    end

    always_comb begin
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        busy      = 1'b0;
        case (cur_state)
            IDLE: key_ready = !rst;
            RUN: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
            end
        endcase
    end

    assign rk_out = key_state[31:0];
    assign rk_idx = idx;
    assign done   = done_q;

endmodule

// File: tb/tb_key_sched_iter.sv
// Bench for key_sched_iter: a 64-bit/25-round and a 128-bit/31-round instance
// checked every cycle against a row-level software model of the schedule.
module tb_key_sched_iter;

    localparam int KW_A = 64;
    localparam int NR_A = 25;
    localparam int KW_B = 128;
    localparam int NR_B = 31;
    localparam int RCW  = 5;
    localparam int SBOX_M [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [KW_A-1:0] a_key_in;
    logic            a_key_valid, a_key_ready, a_rk_valid, a_rk_ready, a_busy, a_done;
    logic [31:0]     a_rk_out;
    logic [RCW-1:0]  a_rk_idx;
    logic [KW_B-1:0] b_key_in;
    logic            b_key_valid, b_key_ready, b_rk_valid, b_rk_ready, b_busy, b_done;
    logic [31:0]     b_rk_out;
    logic [RCW-1:0]  b_rk_idx;

    key_sched_iter #(.KEY_W(KW_A), .NROUNDS(NR_A), .RC_W(RCW)) dut_a (
        .clk(clk), .rst(rst), .key_in(a_key_in), .key_valid(a_key_valid),
        .key_ready(a_key_ready), .rk_out(a_rk_out), .rk_idx(a_rk_idx),
        .rk_valid(a_rk_valid), .rk_ready(a_rk_ready), .busy(a_busy), .done(a_done)
    );

    key_sched_iter #(.KEY_W(KW_B), .NROUNDS(NR_B), .RC_W(RCW)) dut_b (
        .clk(clk), .rst(rst), .key_in(b_key_in), .key_valid(b_key_valid),
        .key_ready(b_key_ready), .rk_out(b_rk_out), .rk_idx(b_rk_idx),
        .rk_valid(b_rk_valid), .rk_ready(b_rk_ready), .busy(b_busy), .done(b_done)
    );

    int          checks = 0;
    int          errors = 0;
    int          nr [2]    = '{NR_A, NR_B};
    int          nrows [2] = '{KW_A / 16, KW_B / 16};
    logic [31:0] seq [2][32];
    int          pos [2]      = '{0, 0};
    bit          running [2]  = '{1'b0, 1'b0};
    bit          done_exp [2] = '{1'b0, 1'b0};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One round on an array of 16-bit rows, straight from the algorithm description.
    function automatic logic [127:0] round_model(input logic [127:0] st, input int rows_n, input int rc);
        logic [15:0]  row [8];
        logic [15:0]  t;
        logic [127:0] res;
        int           n;
        int           s;
        for (int k = 0; k < 8; k++) row[k] = (k < rows_n) ? st[16*k +: 16] : 16'h0;
        for (int j = 0; j < 16; j++) begin
            n = int'(row[0][j]) + 2 * int'(row[1][j]) + 4 * int'(row[2][j]) + 8 * int'(row[3][j]);
            s = SBOX_M[n];
            row[0][j] = s[0];
            row[1][j] = s[1];
            row[2][j] = s[2];
            row[3][j] = s[3];
        end
        t = row[0] ^ ((row[1] << 8) | (row[1] >> 8));
        for (int k = 0; k < rows_n - 1; k++) row[k] = row[k+1];
        row[rows_n-1] = t ^ 16'(rc << (16 - RCW));
        res = '0;
        for (int k = 0; k < rows_n; k++) res[16*k +: 16] = row[k];
        return res;
    endfunction

    task automatic load_seq(input int u, input logic [127:0] key);
        logic [127:0] st;
        st = key;
        for (int i = 0; i < nr[u]; i++) begin
            if (i > 0) st = round_model(st, nrows[u], i);
            seq[u][i] = st[31:0];
        end
    endtask

    // Compare one instance against the model, then advance the model past the coming edge.
    task automatic checkOutput(input int u, input logic kr, input logic rv, input logic bz,
                               input logic dn, input logic [31:0] ro, input int ri,
                               input logic kv, input logic [127:0] ki, input logic rr,
                               input logic rs);
        bit fin;
        if (rs) begin
            running[u]  = 1'b0;
            pos[u]      = 0;
            done_exp[u] = 1'b0;
        end
        check($sformatf("u%0d key_ready", u), 128'(kr), 128'(!running[u] && !rs));
        check($sformatf("u%0d rk_valid", u), 128'(rv), 128'(running[u]));
        check($sformatf("u%0d busy", u), 128'(bz), 128'(running[u]));
        check($sformatf("u%0d done", u), 128'(dn), 128'(done_exp[u]));
        if (running[u]) begin
            check($sformatf("u%0d rk_out idx %0d", u, pos[u]), 128'(ro), 128'(seq[u][pos[u]]));
            check($sformatf("u%0d rk_idx", u), 128'(ri), 128'(pos[u]));
        end
        if (rs) check($sformatf("u%0d rk_out in reset", u), 128'(ro), 128'h0);
        if (!rs) begin
            fin = running[u] && rr && (pos[u] == nr[u] - 1);
            if (!running[u]) begin
                if (kv) begin
                    load_seq(u, ki);
                    running[u] = 1'b1;
                    pos[u]     = 0;
                end
            end else if (rr) begin
                if (pos[u] == nr[u] - 1) running[u] = 1'b0;
                else pos[u]++;
            end
            done_exp[u] = fin;
        end
    endtask

    always @(negedge clk) begin
        checkOutput(0, a_key_ready, a_rk_valid, a_busy, a_done, a_rk_out, int'(a_rk_idx),
                    a_key_valid, 128'(a_key_in), a_rk_ready, rst);
        checkOutput(1, b_key_ready, b_rk_valid, b_busy, b_done, b_rk_out, int'(b_rk_idx),
                    b_key_valid, b_key_in, b_rk_ready, rst);
    end

    task automatic applyStimulus(input logic [63:0] key, input logic kv, input logic rr);
        @(posedge clk);
        #1;
        a_key_in    = key;
        a_key_valid = kv;
        a_rk_ready  = rr;
    endtask

    task automatic wait_done(input int u, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((u == 0) ? a_done : b_done) seen = 1'b1;
        end
        check(name, 128'(seen), 128'h1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen;
        bit found;
        rst = 1'b1;
        a_key_in = '0; a_key_valid = 1'b0; a_rk_ready = 1'b0;
        b_key_in = '0; b_key_valid = 1'b0; b_rk_ready = 1'b0;
        #1;
        check("reset key_ready", 128'(a_key_ready), 128'h0);
        check("reset rk_valid", 128'(a_rk_valid), 128'h0);
        check("reset busy", 128'(a_busy), 128'h0);
        check("reset done", 128'(a_done), 128'h0);
        check("reset rk_out", 128'(a_rk_out), 128'h0);
        check("pin model R64(0,1)", round_model(128'h0, 4, 1), 128'h0800_FFFF_FFFF_0000);
        check("pin model R128(0,1)", round_model(128'h0, 8, 1),
              128'h0800_0000_0000_0000_0000_FFFF_FFFF_0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Zero key on A with ready held high; random 128-bit key on B alongside.
        applyStimulus(64'h0, 1'b1, 1'b1);
        b_key_in    = {$urandom, $urandom, $urandom, $urandom};
        b_key_valid = 1'b1;
        b_rk_ready  = 1'b1;
        applyStimulus(64'h0, 1'b0, 1'b1);
        b_key_valid = 1'b0;
        @(negedge clk);
        check("zero key rk0", 128'(a_rk_out), 128'h0);
        @(negedge clk);
        check("zero key rk1", 128'(a_rk_out), 128'hFFFF_0000);
        wait_done(0, 60, "zero key done");
        wait_done(1, 40, "b 128-bit done");

        // Random stalls on the consumer side.
        applyStimulus(64'h0123456789ABCDEF, 1'b1, 1'b1);
        applyStimulus(64'h0123456789ABCDEF, 1'b0, 1'($urandom_range(0, 1)));
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (a_done) seen = 1'b1;
            a_rk_ready = 1'($urandom_range(0, 1));
        end
        check("stall run done", 128'(seen), 128'h1);

        // Reset while at idx 10, then restart with a fresh key.
        applyStimulus(64'hDEADBEEFCAFEF00D, 1'b1, 1'b1);
        applyStimulus(64'hDEADBEEFCAFEF00D, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (a_rk_valid && a_rk_idx == 5'd10) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("reach idx 10", 128'(found), 128'h1);
        rst = 1'b1;
        #1;
        check("mid reset rk_valid", 128'(a_rk_valid), 128'h0);
        check("mid reset key_ready", 128'(a_key_ready), 128'h0);
        check("mid reset busy", 128'(a_busy), 128'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(64'h1111_2222_3333_4444, 1'b1, 1'b1);
        applyStimulus(64'h1111_2222_3333_4444, 1'b0, 1'b1);
        @(negedge clk);
        check("restart idx", 128'(a_rk_idx), 128'h0);
        check("restart rk0", 128'(a_rk_out), 128'h3333_4444);
        wait_done(0, 60, "restart done");

        // key_valid held high with key_in changing every cycle.
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            a_key_in    = {$urandom, $urandom};
            a_key_valid = 1'b1;
            a_rk_ready  = 1'b1;
            if (i > 0 && a_key_ready) check("accept only with done", 128'(a_done), 128'h1);
        end
        @(posedge clk);
        #1 a_key_valid = 1'b0;
        wait_done(0, 60, "held valid final done");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
